// File: rtl/id_stage.sv
// id_stage: decode stage of the single-issue RV64 core.
// Decodes {pc, inst} from fetch, samples the register-file read data in the
// same cycle, and presents a registered operand bundle to execute. A main
// register plus a skid register keep full throughput with a registered in_ready.
module id_stage #(
  parameter int XLEN        = 64,
  parameter int INST_TYPE_W = 8,
  parameter logic [INST_TYPE_W-1:0] INST_NOP = 8'h00,
  parameter logic [INST_TYPE_W-1:0] INST_ADD = 8'h11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [31:0]            in_inst,
  output logic [4:0]             rs1_addr,
  output logic [4:0]             rs2_addr,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INST_TYPE_W-1:0] out_inst_type,
  output logic [XLEN-1:0]        out_op1,
  output logic [XLEN-1:0]        out_op2,
  output logic [4:0]             out_rd,
  output logic                   out_rd_wen,
  output logic [XLEN-1:0]        out_pc,
  output logic                   out_illegal,
  output logic                   out_halt
);

  typedef struct packed {
    logic [INST_TYPE_W-1:0] inst_type;
    logic [XLEN-1:0]        op1;
    logic [XLEN-1:0]        op2;
    logic [XLEN-1:0]        pc;
    logic [4:0]             rd;
    logic                   rd_wen;
    logic                   illegal;
    logic                   halt;
  } bundle_t;

  localparam logic [31:0] EBREAK = 32'h00100073;

  // Instruction fields and immediates
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];
  assign w_funct7 = in_inst[31:25];
  assign w_imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign w_imm_u  = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};

  // Register-file read addresses come straight from the incoming word
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  bundle_t w_dec;
  logic    w_alu;

  // Decode the incoming instruction into an operand bundle
  always_comb begin
    w_dec           = '0;
    w_dec.inst_type = INST_NOP;
    w_dec.pc        = in_pc;
    w_dec.rd        = in_inst[11:7];
    w_dec.illegal   = 1'b1;
    w_alu           = 1'b0;
    if (in_inst == EBREAK) begin
      w_dec.illegal = 1'b0;
      w_dec.halt    = 1'b1;
    end else begin
      case (w_opcode)
        7'b0010011: begin
          if (w_funct3 == 3'b000) begin
            w_alu     = 1'b1;
            w_dec.op1 = rs1_data;
            w_dec.op2 = w_imm_i;
          end
        end
        7'b0110011: begin
          if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000) begin
            w_alu     = 1'b1;
            w_dec.op1 = rs1_data;
            w_dec.op2 = rs2_data;
          end
        end
        7'b0110111: begin
          w_alu     = 1'b1;
          w_dec.op1 = '0;
          w_dec.op2 = w_imm_u;
        end
        7'b0010111: begin
          w_alu     = 1'b1;
          w_dec.op1 = in_pc;
          w_dec.op2 = w_imm_u;
        end
        default: ;
      endcase
    end
    if (w_alu) begin
      w_dec.inst_type = INST_ADD;
      w_dec.illegal   = 1'b0;
      w_dec.rd_wen    = (in_inst[11:7] != 5'd0);
    end
  end

  // Output buffer state
  bundle_t r_main;
  bundle_t r_skid;
  logic    r_main_valid;
  logic    r_skid_valid;
  logic    r_in_ready;

  logic    w_accept;
  logic    w_main_free;
  logic    w_main_load;
  logic    w_skid_load;
  logic    w_main_valid_next;
  logic    w_skid_valid_next;
  bundle_t w_main_src;

  assign w_accept    = in_valid && r_in_ready;
  assign w_main_free = !r_main_valid || out_ready;

  // Steer the incoming bundle to main or skid; skid refills main when main drains
  always_comb begin
    w_main_load       = 1'b0;
    w_skid_load       = 1'b0;
    w_main_valid_next = r_main_valid;
    w_skid_valid_next = r_skid_valid;
    w_main_src        = w_dec;
    if (w_main_free) begin
      if (r_skid_valid) begin
        w_main_load       = 1'b1;
        w_main_src        = r_skid;
        w_main_valid_next = 1'b1;
        w_skid_load       = w_accept;
        w_skid_valid_next = w_accept;
      end else begin
        w_main_load       = w_accept;
        w_main_valid_next = w_accept;
      end
    end else if (w_accept) begin
      w_skid_load       = 1'b1;
      w_skid_valid_next = 1'b1;
    end
  end

  // Buffer registers: reset clears everything, flush drops all buffered bundles
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main_valid     <= 1'b0;
      r_skid_valid     <= 1'b0;
      r_in_ready       <= 1'b0;
      r_main           <= '0;
      r_main.inst_type <= INST_NOP;
      r_skid           <= '0;
      r_skid.inst_type <= INST_NOP;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_next;
      r_skid_valid <= w_skid_valid_next;
      r_in_ready   <= !w_skid_valid_next;
      if (w_main_load) r_main <= w_main_src;
      if (w_skid_load) r_skid <= w_dec;
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_main_valid;
  assign out_inst_type = r_main.inst_type;
  assign out_op1       = r_main.op1;
  assign out_op2       = r_main.op2;
  assign out_rd        = r_main.rd;
  assign out_rd_wen    = r_main.rd_wen;
  assign out_pc        = r_main.pc;
  assign out_illegal   = r_main.illegal;
  assign out_halt      = r_main.halt;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the single-issue RV64 core.
- Accepts {pc, inst} from fetch over a valid/ready handshake and reads two register-file ports.
- Produces the registered operand bundle consumed by the execute stage: inst_type, op1, op2, rd, rd_wen.
- A 2-entry output buffer (main register plus skid register) gives full throughput with a registered in_ready.

Parameters:
- XLEN, 64: data/operand width (matches REG_BUS).
- INST_TYPE_W, 8: width of inst_type code.
- INST_NOP, 8'h00: inst_type for illegal/bubble.
- INST_ADD, 8'h11: inst_type for add-class operations.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  discard all buffered and incoming instructions.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  stage can accept this cycle (registered).
- in_pc  in  XLEN  instruction address.
- in_inst  in  32  instruction word.
- rs1_addr  out  5  regfile read port 1 index (combinational from in_inst[19:15]).
- rs2_addr  out  5  regfile read port 2 index (in_inst[24:20]).
- rs1_data  in  XLEN  regfile read data 1 (combinational; regfile returns 0 for x0).
- rs2_data  in  XLEN  regfile read data 2.
- out_valid  out  1  bundle valid to execute.
- out_ready  in  1  execute accepts bundle.
- out_inst_type  out  INST_TYPE_W  operation code.
- out_op1  out  XLEN  operand 1.
- out_op2  out  XLEN  operand 2.
- out_rd  out  5  destination register.
- out_rd_wen  out  1  writeback enable.
- out_pc  out  XLEN  pc of bundle.
- out_illegal  out  1  unsupported encoding.
- out_halt  out  1  ebreak reached.

Behaviour:
- Reset (rst==0 at an edge): out_valid=0, skid empty, all out_* data = 0, out_inst_type=INST_NOP.
- in_ready is 0 while rst==0 and is 1 in the first cycle after release.
- Transfer in: in_valid && in_ready at a rising edge. Operands (rs1_data/rs2_data) are sampled in that same cycle.
- Hazard checking is out of scope.
- Latency: a bundle accepted at edge N is on out_* with out_valid=1 after edge N.
- Transfer out: out_valid && out_ready at an edge.
- out_* stay stable while out_valid && !out_ready.
- Buffering:
  - If main is empty, or main drains this cycle, the incoming bundle loads main.
  - Otherwise the incoming bundle loads skid.
  - When main drains and skid is full, skid moves to main. A simultaneous incoming bundle then goes to skid.
  - in_ready(next) = !skid_full(next).
  - Order is always preserved; no drops, no duplicates.
- Decode:
  - addi (opcode 0010011, funct3 000): type=INST_ADD; op1=rs1_data; op2=sext(inst[31:20]).
  - add (opcode 0110011, funct3 000, funct7 0000000): type=INST_ADD; op1=rs1_data; op2=rs2_data.
  - lui (0110111): type=INST_ADD; op1=0; op2=sext({inst[31:12],12'b0}).
  - auipc (0010111): type=INST_ADD; op1=pc; op2=sext({inst[31:12],12'b0}).
  - ebreak (32'h00100073): type=INST_NOP; halt=1; rd_wen=0.
  - Anything else: type=INST_NOP; illegal=1; rd_wen=0; op1=op2=0.
  - out_rd=inst[11:7] in all cases.
  - rd_wen=1 only for the four ALU instructions and only when rd!=0.
- Sign extension is to XLEN; U-immediates are extended from bit 31.
- flush=1 at an edge (and rst==1):
  - out_valid=0 and skid empty next cycle.
  - A same-cycle incoming bundle is discarded.
  - A same-cycle out transfer still counts as completed by execute.
  - in_ready=1 next cycle.
- Priority: reset > flush > normal.

Test Plan:
- addi x5,x1,-1 (0xFFF08293), rs1_data=0x10, out_ready=1 -> one cycle later: out_valid=1, type=8'h11, op1=0x10, op2=0xFFFFFFFFFFFFFFFF, rd=5, rd_wen=1.
- lui x3,0x12345 (0x123451B7) then auipc x1,0x80000 (0x80000097) at pc 0x80000004 -> lui gives op1=0, op2=0x12345000; auipc gives op1=0x80000004, op2=0xFFFFFFFF80000000. Back-to-back bundles arrive on consecutive cycles.
- out_ready=0, three instructions offered on consecutive cycles -> first two held (main, skid), in_ready=0 after second acceptance, third held by fetch. Raise out_ready -> all three emerge in order, one per cycle.
- 0x00000000 -> illegal=1, type=8'h00, rd_wen=0. 0x00100073 -> halt=1. addi x0,x0,1 (0x00100013) -> rd_wen=0.
- Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed bundles never appear.
- rst=0 for one cycle while bundles are buffered -> out_valid=0, out_inst_type=8'h00, out_op1=0. in_ready=0 during reset, then 1.
